// File: rtl/tcp_vlg_ack_sched.sv
// Delayed/forced pure-ack scheduler: per-connection packet and timeout triggers, round-robin grant, one request in flight.
// Build option: define TCP_VLG_ACK_SACK_EN to let sack_upd force an ack on a connected connection.
module tcp_vlg_ack_sched #(
  parameter int N_CONN            = 4,
  parameter int TIMEOUT           = 1250,
  parameter int FORCE_ACK_PACKETS = 5,
  parameter int CW                = (N_CONN > 1) ? $clog2(N_CONN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CONN-1:0]    connected,
  input  logic [N_CONN*32-1:0] loc_ack,
  input  logic [N_CONN*32-1:0] rep_ack,
  input  logic                 rx_sof,
  input  logic                 rx_val,
  input  logic [CW-1:0]        rx_conn,
  input  logic [31:0]          rx_seq_end,
  input  logic [N_CONN-1:0]    sack_upd,
  output logic                 ack_req,
  output logic [CW-1:0]        ack_conn,
  output logic [31:0]          ack_num,
  input  logic                 ack_sent
);

  localparam int CNT_W = $clog2(FORCE_ACK_PACKETS + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FORCE_ACK_PACKETS);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      ack_conn_q, ack_conn_d;
  logic [31:0]        ack_num_q, ack_num_d;
  logic [N_CONN-1:0]  acked_q, acked_d;
  logic [N_CONN-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q [N_CONN];
  logic [CNT_W-1:0]   cnt_d [N_CONN];
  logic [TMR_W-1:0]   tmr_q [N_CONN];
  logic [TMR_W-1:0]   tmr_d [N_CONN];
  logic [N_CONN-1:0]  pkts_trig, tmo_trig, sack_trig, ack_done;
  logic               grant_vld;
  logic [CW-1:0]      grant_idx;
  logic [31:0]        grant_num;
  int                 idx;

`ifdef TCP_VLG_ACK_SACK_EN
  assign sack_trig = sack_upd & connected;
`else
  logic unused_sack;
  assign unused_sack = ^sack_upd;
  assign sack_trig   = '0;
`endif

  always_comb begin
    for (int i = 0; i < N_CONN; i++) begin
      acked_d[i]   = (loc_ack[i*32 +: 32] == rep_ack[i*32 +: 32]);
      ack_done[i]  = (state_q == REQ) && ack_sent && (ack_conn_q == CW'(i));
      pkts_trig[i] = (cnt_q[i] == CNT_MAX);
      tmo_trig[i]  = (tmr_q[i] == TMR_FIRE);

      if (acked_q[i] || !connected[i] || ack_done[i])
        cnt_d[i] = '0;
      else if (rx_sof && (rx_conn == CW'(i)) && !pkts_trig[i])
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else
        cnt_d[i] = cnt_q[i];

      // New out-of-order/unexpected data restarts the delayed-ack window
      if (!connected[i] || acked_q[i] ||
          (rx_val && (rx_conn == CW'(i)) && (rx_seq_end != loc_ack[i*32 +: 32])))
        tmr_d[i] = '0;
      else if (tmr_q[i] != TMR_MAX)
        tmr_d[i] = tmr_q[i] + TMR_W'(1);
      else
        tmr_d[i] = tmr_q[i];

      // A fresh trigger beats the completion clear; disconnect clears everything
      pending_d[i] = connected[i] &
                     (pkts_trig[i] | tmo_trig[i] | sack_trig[i] | (pending_q[i] & ~ack_done[i]));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ack_conn_d = ack_conn_q;
    ack_num_d  = ack_num_q;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_num  = '0;
    idx        = 0;
    // Scan downward so the candidate nearest rr_ptr is the one left standing
    for (int k = N_CONN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CONN) idx = idx - N_CONN;
      if (pending_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(idx);
        grant_num = loc_ack[idx*32 +: 32];
      end
    end
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          ack_conn_d = grant_idx;
          ack_num_d  = grant_num;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (ack_sent) begin
          state_d  = IDLE;
          rr_ptr_d = (ack_conn_q == CW'(N_CONN - 1)) ? '0 : ack_conn_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      ack_conn_q <= '0;
      ack_num_q  <= '0;
      acked_q    <= '0;
      pending_q  <= '0;
      for (int i = 0; i < N_CONN; i++) begin
        cnt_q[i] <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_conn_q <= ack_conn_d;
      ack_num_q  <= ack_num_d;
      acked_q    <= acked_d;
      pending_q  <= pending_d;
      for (int i = 0; i < N_CONN; i++) begin
        cnt_q[i] <= cnt_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign ack_req  = (state_q == REQ);
  assign ack_conn = ack_conn_q;
  assign ack_num  = ack_num_q;

endmodule

// File: tb/tb_tcp_vlg_ack_sched.sv
// Directed bench for tcp_vlg_ack_sched: timeout, packet-count, round-robin, latching, reset and SACK scenarios.
module tb_tcp_vlg_ack_sched;
  localparam int N_CONN  = 4;
  localparam int TIMEOUT = 1250;
  localparam int FAP     = 5;
  localparam int CW      = 2;
`ifdef TCP_VLG_ACK_SACK_EN
  localparam logic SACK_EXP = 1'b1;
`else
  localparam logic SACK_EXP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CONN-1:0]    connected;
  logic [N_CONN*32-1:0] loc_ack, rep_ack;
  logic                 rx_sof, rx_val;
  logic [CW-1:0]        rx_conn;
  logic [31:0]          rx_seq_end;
  logic [N_CONN-1:0]    sack_upd;
  logic                 ack_req;
  logic [CW-1:0]        ack_conn;
  logic [31:0]          ack_num;
  logic                 ack_sent;

  int checks = 0;
  int errors = 0;

  tcp_vlg_ack_sched #(.N_CONN(N_CONN), .TIMEOUT(TIMEOUT), .FORCE_ACK_PACKETS(FAP), .CW(CW)) dut (
    .clk(clk), .rst(rst), .connected(connected), .loc_ack(loc_ack), .rep_ack(rep_ack),
    .rx_sof(rx_sof), .rx_val(rx_val), .rx_conn(rx_conn), .rx_seq_end(rx_seq_end),
    .sack_upd(sack_upd), .ack_req(ack_req), .ack_conn(ack_conn), .ack_num(ack_num),
    .ack_sent(ack_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int max_cyc, input string tag);
    int n = 0;
    while (ack_req !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, ack_req}, 32'd1);
  endtask

  task automatic sofs(input int n, input logic [CW-1:0] c);
    for (int i = 0; i < n; i++) begin
      rx_sof = 1'b1; rx_conn = c;
      tick();
    end
    rx_sof = 1'b0;
  endtask

  task automatic send_ack();
    ack_sent = 1'b1;
    tick();
    ack_sent = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack_req) send_ack();
    end
  endtask

  initial begin
    rst = 1'b1; connected = '0; loc_ack = '0; rep_ack = '0;
    rx_sof = 1'b0; rx_val = 1'b0; rx_conn = '0; rx_seq_end = '0;
    sack_upd = '0; ack_sent = 1'b0;
    tick(); tick();
    chk("rst_req", {31'd0, ack_req}, 32'd0);
    chk("rst_conn", {30'd0, ack_conn}, 32'd0);
    chk("rst_num", ack_num, 32'd0);
    rst = 1'b0;

    // Timeout-driven ack on connection 2
    connected = 4'b0100;
    loc_ack[2*32 +: 32] = 32'h1000; rep_ack[2*32 +: 32] = 32'h1000;
    tick(); tick(); tick();
    loc_ack[2*32 +: 32] = 32'h2000;
    repeat (TIMEOUT + 1) tick();
    chk("tmo_early", {31'd0, ack_req}, 32'd0);
    tick();
    chk("tmo_req", {31'd0, ack_req}, 32'd1);
    chk("tmo_conn", {30'd0, ack_conn}, 32'd2);
    chk("tmo_num", ack_num, 32'h2000);
    send_ack();
    chk("tmo_done", {31'd0, ack_req}, 32'd0);
    tick();
    chk("tmo_no_retrig", {31'd0, ack_req}, 32'd0);
    rep_ack[2*32 +: 32] = 32'h2000;

    // Packet-count forced ack on connection 1
    loc_ack[1*32 +: 32] = 32'h3100; rep_ack[1*32 +: 32] = 32'h3000;
    connected = 4'b0110;
    tick(); tick();
    sofs(FAP, 2'd1);
    chk("pkts_cnt", {27'd0, dut.cnt_q[1]}, FAP);
    tick();
    chk("pkts_early", {31'd0, ack_req}, 32'd0);
    tick();
    chk("pkts_req", {31'd0, ack_req}, 32'd1);
    chk("pkts_conn", {30'd0, ack_conn}, 32'd1);
    chk("pkts_num", ack_num, 32'h3100);
    send_ack();
    chk("pkts_cnt_clr", {27'd0, dut.cnt_q[1]}, 32'd0);
    drain();
    chk("pkts_drained", {31'd0, ack_req}, 32'd0);
    rep_ack[1*32 +: 32] = 32'h3100;

    // Latched ack number and disconnect during REQ on connection 0
    loc_ack[0*32 +: 32] = 32'h5000; rep_ack[0*32 +: 32] = 32'h4000;
    connected = 4'b0111;
    tick(); tick();
    sofs(FAP, 2'd0);
    tick(); tick();
    chk("latch_req", {31'd0, ack_req}, 32'd1);
    chk("latch_conn", {30'd0, ack_conn}, 32'd0);
    loc_ack[0*32 +: 32] = 32'h5555;
    tick(); tick();
    chk("latch_num", ack_num, 32'h5000);
    connected = 4'b0110;
    tick();
    chk("drop_hold_req", {31'd0, ack_req}, 32'd1);
    chk("drop_hold_num", ack_num, 32'h5000);

    // Reset while a request is outstanding
    rst = 1'b1;
    tick();
    chk("rstreq_req", {31'd0, ack_req}, 32'd0);
    chk("rstreq_num", ack_num, 32'd0);
    chk("rstreq_cnt", {27'd0, dut.cnt_q[0]}, 32'd0);
    chk("rstreq_pend", {28'd0, dut.pending_q}, 32'd0);
    rst = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (ack_req) seen = 1'b1;
      end
      chk("rstreq_quiet", {31'd0, seen}, 32'd0);
    end

    // Round-robin among 0, 1, 3 pending together
    connected = '0;
    loc_ack[0*32 +: 32] = 32'h6000; rep_ack[0*32 +: 32] = 32'h6001;
    loc_ack[1*32 +: 32] = 32'h7000; rep_ack[1*32 +: 32] = 32'h7001;
    loc_ack[3*32 +: 32] = 32'h8000; rep_ack[3*32 +: 32] = 32'h8001;
    tick(); tick();
    connected = 4'b1011;
    wait_req(TIMEOUT + 10, "rr_first_req");
    chk("rr_first", {30'd0, ack_conn}, 32'd0);
    chk("rr_first_num", ack_num, 32'h6000);
    tick(); send_ack();
    chk("rr_gap1", {31'd0, ack_req}, 32'd0);
    tick();
    chk("rr_second_req", {31'd0, ack_req}, 32'd1);
    chk("rr_second", {30'd0, ack_conn}, 32'd1);
    chk("rr_second_num", ack_num, 32'h7000);
    tick(); send_ack();
    chk("rr_gap2", {31'd0, ack_req}, 32'd0);
    tick();
    chk("rr_third_req", {31'd0, ack_req}, 32'd1);
    chk("rr_third", {30'd0, ack_conn}, 32'd3);
    chk("rr_third_num", ack_num, 32'h8000);
    tick(); send_ack();
    tick();
    chk("rr_idle", {31'd0, ack_req}, 32'd0);

    // ack_sent in IDLE has no effect, then re-pend connection 0
    sofs(3, 2'd0);
    send_ack();
    chk("idle_ack_cnt", {27'd0, dut.cnt_q[0]}, 32'd3);
    chk("idle_ack_req", {31'd0, ack_req}, 32'd0);
    sofs(2, 2'd0);
    tick(); tick();
    chk("rr_wrap_req", {31'd0, ack_req}, 32'd1);
    chk("rr_wrap", {30'd0, ack_conn}, 32'd0);
    send_ack();
    drain();

    // SACK update on an acked connection
    rep_ack[0*32 +: 32] = loc_ack[0*32 +: 32];
    rep_ack[1*32 +: 32] = loc_ack[1*32 +: 32];
    rep_ack[3*32 +: 32] = loc_ack[3*32 +: 32];
    tick(); tick(); tick();
    chk("sack_pre", {31'd0, ack_req}, 32'd0);
    sack_upd = 4'b1000;
    tick();
    sack_upd = '0;
    tick();
    chk("sack_req", {31'd0, ack_req}, {31'd0, SACK_EXP});
    chk("sack_conn", {30'd0, ack_conn}, SACK_EXP ? 32'd3 : 32'd0);
    drain();
    chk("sack_end", {31'd0, ack_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
